// File: rtl/fft3d_pkg.sv
// Shared definitions for the 3D FFT engine: sequencer state encoding, one-hot
// dimension codes, default grid/FFT sizing and the pass-order lookup.
package fft3d_pkg;

   localparam int DEFAULT_DIMENSION   = 16;
   localparam int DEFAULT_NUM_FFTS    = 4;
   localparam int DEFAULT_FFT_LATENCY = 16;

   localparam logic [2:0] DIM_NONE = 3'b000;
   localparam logic [2:0] DIM_X    = 3'b001;
   localparam logic [2:0] DIM_Y    = 3'b010;
   localparam logic [2:0] DIM_Z    = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } seq_state_t;

   // Forward transforms sweep X,Y,Z; inverse transforms unwind them as Z,Y,X.
   function automatic logic [2:0] pass_dim(input logic [1:0] pass, input logic inv);
      logic [2:0] dim;
      dim = DIM_NONE;
      case (pass)
         2'd0:    dim = inv ? DIM_Z : DIM_X;
         2'd1:    dim = DIM_Y;
         2'd2:    dim = inv ? DIM_X : DIM_Z;
         default: dim = DIM_NONE;
      endcase
      return dim;
   endfunction

endpackage

// File: rtl/fft3d_sequencer.sv
// Sequences the three line-FFT passes of a 3D FFT over a DIMENSION^3 grid,
// driving the memory controller's dimension select and iteration index.
module fft3d_sequencer
   import fft3d_pkg::*;
#(
   parameter int DIMENSION   = DEFAULT_DIMENSION,
   parameter int NUM_FFTS    = DEFAULT_NUM_FFTS,
   parameter int FFT_LATENCY = DEFAULT_FFT_LATENCY,
   parameter int ITER_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  inverse,
   input  logic                  abort,
   input  logic                  fft_ready,
   output logic [2:0]            FFT_dim,
   output logic [ITER_WIDTH-1:0] FFT_iteration,
   output logic                  fft_rd_en,
   output logic                  fft_wr_en,
   output logic                  busy,
   output logic                  pass_done,
   output logic                  done
);

   localparam int LOAD_CYCLES = DIMENSION * DIMENSION;
   localparam int PASS_LEN    = LOAD_CYCLES + FFT_LATENCY;

   localparam logic [ITER_WIDTH-1:0] LOAD_END  = ITER_WIDTH'(LOAD_CYCLES);
   localparam logic [ITER_WIDTH-1:0] WB_START  = ITER_WIDTH'(FFT_LATENCY);
   localparam logic [ITER_WIDTH-1:0] PASS_LAST = ITER_WIDTH'(PASS_LEN - 1);

   if (NUM_FFTS < 1 || ITER_WIDTH < $clog2(PASS_LEN)) begin : g_bad_params
      $error("fft3d_sequencer: NUM_FFTS must be >= 1 and ITER_WIDTH must hold PASS_LEN-1");
   end

   seq_state_t            state_reg, state_next;
   logic [ITER_WIDTH-1:0] iter_reg, iter_next;
   logic [1:0]            pass_reg, pass_next;
   logic                  inv_reg, inv_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         iter_reg  <= '0;
         pass_reg  <= 2'd0;
         inv_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         iter_reg  <= iter_next;
         pass_reg  <= pass_next;
         inv_reg   <= inv_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      iter_next  = iter_reg;
      pass_next  = pass_reg;
      inv_next   = inv_reg;

      if (abort) begin
         state_next = ST_IDLE;
         iter_next  = '0;
         pass_next  = 2'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  inv_next   = inverse;
                  pass_next  = 2'd0;
                  iter_next  = '0;
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               // A stall freezes everything, including the final-iteration exit.
               if (fft_ready) begin
                  if (iter_reg == PASS_LAST) begin
                     iter_next  = '0;
                     state_next = (pass_reg == 2'd2) ? ST_FIN : ST_GAP;
                  end else begin
                     iter_next = iter_reg + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               pass_next  = pass_reg + 2'd1;
               state_next = ST_RUN;
            end
            ST_FIN: begin
               pass_next  = 2'd0;
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
               iter_next  = '0;
               pass_next  = 2'd0;
            end
         endcase
      end
   end

   logic run_active;

   always_comb begin
      run_active    = (state_reg == ST_RUN);
      FFT_dim       = run_active ? pass_dim(pass_reg, inv_reg) : DIM_NONE;
      FFT_iteration = iter_reg;
      // Load and write-back windows overlap once the pipeline has filled.
      fft_rd_en     = run_active && fft_ready && (iter_reg < LOAD_END);
      fft_wr_en     = run_active && fft_ready && (iter_reg >= WB_START);
      busy          = (state_reg != ST_IDLE);
      pass_done     = (state_reg == ST_GAP) || (state_reg == ST_FIN);
      done          = (state_reg == ST_FIN);
   end

endmodule

// File: tb/tb_fft3d_sequencer.sv
// Scoreboard bench for fft3d_sequencer: stimulus queues expected pass completions,
// a negedge monitor checks every cycle and pops on each pass_done pulse.
module tb_fft3d_sequencer;

   localparam int IW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          inverse = 1'b0;
   logic          abort = 1'b0;
   logic          fft_ready = 1'b1;
   logic [2:0]    FFT_dim;
   logic [IW-1:0] FFT_iteration;
   logic          fft_rd_en;
   logic          fft_wr_en;
   logic          busy;
   logic          pass_done;
   logic          done;

   fft3d_sequencer #(
      .DIMENSION  (16),
      .NUM_FFTS   (4),
      .FFT_LATENCY(16),
      .ITER_WIDTH (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .inverse      (inverse),
      .abort        (abort),
      .fft_ready    (fft_ready),
      .FFT_dim      (FFT_dim),
      .FFT_iteration(FFT_iteration),
      .fft_rd_en    (fft_rd_en),
      .fft_wr_en    (fft_wr_en),
      .busy         (busy),
      .pass_done    (pass_done),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [2:0] dim;
      logic       fin;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hand-computed pass completion cycles, counted from the start-sampling edge.
   task automatic push_run(input logic inv, input int stall);
      exp_t e;
      e.cyc = 273 + stall; e.dim = inv ? 3'b100 : 3'b001; e.fin = 1'b0; q.push_back(e);
      e.cyc = 546 + stall; e.dim = 3'b010;                e.fin = 1'b0; q.push_back(e);
      e.cyc = 819 + stall; e.dim = inv ? 3'b001 : 3'b100; e.fin = 1'b1; q.push_back(e);
   endtask

   // Monitor
   int         cyc = 0;
   int         exp_iter = 0;
   int         seg_len = 0;
   logic       seg_active = 1'b0;
   logic [2:0] seg_dim = 3'b000;
   exp_t       em;

   always @(negedge clk) begin
      if (!busy) begin
         cyc = 0;
         seg_active = 1'b0;
         check("idle_outputs",
               int'({FFT_dim, fft_rd_en, fft_wr_en, pass_done, done, FFT_iteration}), 0);
      end else begin
         cyc++;
         if (FFT_dim != 3'b000) begin
            if (!seg_active) begin
               seg_active = 1'b1;
               seg_dim = FFT_dim;
               exp_iter = 0;
               seg_len = 0;
            end
            check("dim_stable", int'(FFT_dim), int'(seg_dim));
            check("iteration", int'(FFT_iteration), exp_iter);
            check("rd_en", int'(fft_rd_en), int'(fft_ready && exp_iter < 256));
            check("wr_en", int'(fft_wr_en), int'(fft_ready && exp_iter >= 16));
            if (fft_ready) begin
               exp_iter++;
               seg_len++;
            end
         end
         if (pass_done) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pass_done: got pulse at cycle %0d expected none", cyc);
            end else begin
               em = q.pop_front();
               check("pass_done_cycle", cyc, em.cyc);
               check("pass_dim", int'(seg_dim), int'(em.dim));
               check("pass_len", seg_len, 272);
               check("done_flag", int'(done), int'(em.fin));
               check("gap_dim", int'(FFT_dim), 0);
            end
            seg_active = 1'b0;
         end else if (done) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_done: got done without pass_done at cycle %0d expected 0", cyc);
         end
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic inv);
      start = 1'b1;
      inverse = inv;
      tick();
      start = 1'b0;
      inverse = ~inv;
   endtask

   task automatic wait_iter(input logic [2:0] dim, input int it);
      int n;
      n = 0;
      while (!(FFT_dim == dim && int'(FFT_iteration) == it) && n < 1200) begin
         tick();
         n++;
      end
      if (n >= 1200) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_iter_timeout: got no dim %0d iter %0d expected within 1200 cycles", dim, it);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1500) begin
         tick();
         n++;
      end
      if (n >= 1500) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle_timeout: got busy=1 expected idle within 1500 cycles");
         abort = 1'b1;
         tick();
         abort = 1'b0;
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      #13;
      check("reset_busy", int'(busy), 0);
      check("reset_outputs",
            int'({FFT_dim, fft_rd_en, fft_wr_en, pass_done, done, FFT_iteration}), 0);
      #4 rst = 1'b1;
      tick(); tick();

      // Forward run
      push_run(1'b0, 0);
      do_start(1'b0);
      wait_idle();
      tick();

      // Inverse run
      push_run(1'b1, 0);
      do_start(1'b1);
      wait_idle();
      tick();

      // Five-cycle stall at iteration 100 of pass 0
      push_run(1'b0, 5);
      do_start(1'b0);
      wait_iter(3'b001, 100);
      fft_ready = 1'b0;
      repeat (5) tick();
      check("stall_hold_iter", int'(FFT_iteration), 100);
      fft_ready = 1'b1;
      wait_idle();
      tick();

      // Abort at pass 1 iteration 50, with a simultaneous start
      begin
         exp_t e;
         e.cyc = 273; e.dim = 3'b001; e.fin = 1'b0;
         q.push_back(e);
      end
      do_start(1'b0);
      wait_iter(3'b010, 50);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_outputs",
            int'({FFT_dim, fft_rd_en, fft_wr_en, pass_done, done, FFT_iteration}), 0);
      repeat (3) tick();
      check("abort_stays_idle", int'(busy), 0);
      push_run(1'b0, 0);
      do_start(1'b0);
      wait_idle();
      tick();

      // Asynchronous reset mid-pass
      do_start(1'b1);
      wait_iter(3'b100, 30);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_outputs",
            int'({FFT_dim, fft_rd_en, fft_wr_en, pass_done, done, FFT_iteration}), 0);
      tick();
      #2 rst = 1'b1;
      tick(); tick();

      // Starts while busy must not restart or re-latch inverse
      push_run(1'b1, 0);
      do_start(1'b1);
      wait_iter(3'b100, 100);
      start = 1'b1;
      inverse = 1'b0;
      tick();
      start = 1'b0;
      wait_iter(3'b001, 5);
      start = 1'b1;
      inverse = 1'b0;
      tick();
      start = 1'b0;
      wait_idle();
      repeat (3) tick();

      check("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fft3d_sequencer.md
FFT3D_SEQUENCER -- requirements
Module: fft3d_sequencer

Interface
REQ-001 Parameter DIMENSION, default 16, points per FFT line and grid edge length.
REQ-002 Parameter NUM_FFTS, default 4, parallel FFT cores fed by the memory controller.
REQ-003 Parameter FFT_LATENCY, default 16, cycles from first FFT input to first FFT output.
REQ-004 Parameter ITER_WIDTH, default 11, width of the iteration counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to run a full 3D FFT; honoured only in IDLE.
REQ-008 inverse  input  1  sampled with start; 0 selects pass order X,Y,Z, 1 selects pass order Z,Y,X.
REQ-009 abort  input  1  synchronous cancel of any run in progress.
REQ-010 fft_ready  input  1  FFT cores can advance; 0 stalls the sequence.
REQ-011 FFT_dim  output  3  one-hot active dimension to the memory controller (001 X, 010 Y, 100 Z, 000 none).
REQ-012 FFT_iteration  output  ITER_WIDTH  current iteration index within the pass.
REQ-013 fft_rd_en  output  1  the grid-to-FFT load phase is active.
REQ-014 fft_wr_en  output  1  the FFT-to-grid write-back phase is active.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 pass_done  output  1  one-cycle pulse after each completed pass.
REQ-017 done  output  1  one-cycle pulse after all three passes complete.

Function
REQ-018 The block SHALL define LOAD_CYCLES = DIMENSION*DIMENSION and PASS_LEN = LOAD_CYCLES + FFT_LATENCY (272 at defaults).
REQ-019 The FSM SHALL have the states IDLE, RUN, GAP and FIN.
REQ-020 In IDLE, start=1 SHALL latch inverse, select pass 0 and enter RUN on the next edge with FFT_iteration=0.
REQ-021 In RUN, FFT_dim SHALL be the one-hot code of the current pass; every other state SHALL drive 000.
REQ-022 In RUN with fft_ready=1, FFT_iteration SHALL increment by 1; with fft_ready=0 it SHALL hold, and fft_rd_en and fft_wr_en SHALL be 0.
REQ-023 fft_rd_en SHALL equal RUN & fft_ready & (FFT_iteration < LOAD_CYCLES).
REQ-024 fft_wr_en SHALL equal RUN & fft_ready & (FFT_iteration >= FFT_LATENCY).
REQ-025 In RUN with fft_ready=1 and FFT_iteration=PASS_LEN-1:
  - passes 0 and 1: go to GAP;
  - pass 2: go to FIN;
  - in both cases FFT_iteration SHALL reset to 0.
REQ-026 GAP SHALL last exactly one cycle, assert pass_done, advance the pass index and return to RUN.
REQ-027 FIN SHALL last one cycle, assert pass_done and done, and return to IDLE.
REQ-028 Without stalls, done SHALL assert 819 cycles after the edge that samples start (1+3*272+2).
REQ-029 start received outside IDLE SHALL be ignored, and inverse SHALL not be re-sampled.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge with all outputs 0 and no done pulse; abort has priority over start in the same cycle.
REQ-031 A stall on the final iteration SHALL hold the state until fft_ready returns.

Reset
REQ-032 While rst=0, the FSM SHALL be in IDLE, and FFT_dim, FFT_iteration, fft_rd_en, fft_wr_en, busy, pass_done and done SHALL be 0.
REQ-033 Reset asserted mid-run SHALL discard the run, and no done pulse SHALL be produced.

Structure
REQ-034 The FSM state enum, the one-hot dimension constants DIM_X, DIM_Y, DIM_Z and DIM_NONE, and the defaults DIMENSION, NUM_FFTS and FFT_LATENCY SHALL live in a shared package fft3d_pkg, also used by memoryCtrl.
REQ-035 The block SHALL be implemented as a single module with no sub-modules; the pass-order lookup SHALL be a combinational function in fft3d_pkg.

Verification
REQ-036 Scenario: forward run.
  - Stimulus: start with inverse=0, fft_ready=1.
  - Response: FFT_dim sequence 001,000,010,000,100, each code held 272 cycles, FFT_iteration 0..271, done at cycle 819.
REQ-037 Scenario: inverse run.
  - Stimulus: start with inverse=1.
  - Response: FFT_dim order 100,010,001, and pass_done pulses at cycles 273, 546 and 819.
REQ-038 Scenario: stall.
  - Stimulus: fft_ready=0 for 5 cycles at iteration 100 of pass 0.
  - Response: FFT_iteration holds at 100, rd_en and wr_en are 0, done is at cycle 824.
REQ-039 Scenario: abort.
  - Stimulus: abort at pass 1, iteration 50.
  - Response: next cycle is IDLE, all outputs 0, done never pulses, and a new start runs normally.
REQ-040 Scenario: phase boundaries.
  - Stimulus: an unstalled pass.
  - Response: fft_rd_en is high for iterations 0..255, fft_wr_en is high for iterations 16..271, and both are high for iterations 16..255.
REQ-041 Scenario: async reset and ignored start.
  - Stimulus: rst=0 asserted mid-pass, then a start pulse issued while busy.
  - Response: outputs go to 0 immediately on rst=0, and the start while busy does not alter the sequence or the latched inverse.
